// File: rtl/key_matrix_scanner.sv
// rtl/key_matrix_scanner.sv - column-strobed key matrix scanner with one shared debounce engine and a single event slot
// Optional feature macro: KEYSCAN_RELEASE_EVT_EN (release events; press-only when undefined)
module key_matrix_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4,
  localparam int NKEYS  = ROWS * COLS,
  localparam int CODE_W = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [COLS-1:0]   col_n,
  input  logic [ROWS-1:0]   row_n,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {S_DRIVE, S_SETTLE, S_SAMPLE, S_NEXT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ROWS-1:0]   r_sync1;
  logic [ROWS-1:0]   r_sync2;
  logic [COLS-1:0]   r_col_n;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [SET_W-1:0]  r_settle;
  logic [NKEYS-1:0]  r_stable;
  logic [CNT_W-1:0]  r_count [NKEYS];
  logic              r_evt_valid;
  logic [CODE_W-1:0] r_evt_code;
  logic              r_evt_press;

  logic [CODE_W-1:0] w_key;
  logic              w_sample;
  logic              w_differ;
  logic              w_flip;
  logic              w_gen;
  logic              w_stall;
  logic              w_eval;

  assign col_n     = r_col_n;
  assign evt_valid = r_evt_valid;
  assign evt_code  = r_evt_code;
  assign evt_press = r_evt_press;

  // Row pins idle high (released) so the synchroniser resets to ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= row_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_key    = CODE_W'(int'(r_col) * ROWS + int'(r_row));
  assign w_sample = ~r_sync2[r_row];
  assign w_differ = (w_sample != r_stable[w_key]);
  assign w_flip   = w_differ && (r_count[w_key] == CNT_W'(DEBOUNCE_SCANS - 1));
`ifdef KEYSCAN_RELEASE_EVT_EN
  assign w_gen    = w_flip;
`else
  assign w_gen    = w_flip && w_sample;
`endif
  // A key that needs the slot while it is still occupied freezes the whole scan.
  assign w_stall  = (r_state == S_SAMPLE) && w_gen && r_evt_valid && !evt_ready;
  assign w_eval   = (r_state == S_SAMPLE) && !w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_DRIVE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_DRIVE:  w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_settle == SET_W'(SETTLE_CYCLES - 1)) w_state_nxt = S_SAMPLE;
      S_SAMPLE: if (!w_stall && (r_row == ROW_W'(ROWS - 1))) w_state_nxt = S_NEXT;
      default:  w_state_nxt = S_DRIVE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_n  <= '1;
      r_col    <= '0;
      r_row    <= '0;
      r_settle <= '0;
    end else begin
      case (r_state)
        S_DRIVE: begin
          r_col_n  <= ~(COLS'(1) << r_col);
          r_settle <= '0;
        end
        S_SETTLE: r_settle <= r_settle + 1'b1;
        S_SAMPLE: begin
          if (!w_stall) r_row <= (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;
        end
        default: begin
          r_col_n <= '1;
          r_col   <= (r_col == COL_W'(COLS - 1)) ? '0 : r_col + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= '0;
      for (int k = 0; k < NKEYS; k++) r_count[k] <= '0;
    end else if (w_eval) begin
      if (!w_differ) begin
        r_count[w_key] <= '0;
      end else if (!w_flip) begin
        r_count[w_key] <= r_count[w_key] + 1'b1;
      end else begin
        r_stable[w_key] <= w_sample;
        r_count[w_key]  <= '0;
      end
    end
  end

  // Loading has priority so a resumed key lands in the slot on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_evt_valid <= 1'b0;
      r_evt_code  <= '0;
      r_evt_press <= 1'b0;
    end else if (w_eval && w_gen) begin
      r_evt_valid <= 1'b1;
      r_evt_code  <= w_key;
      r_evt_press <= w_sample;
    end else if (r_evt_valid && evt_ready) begin
      r_evt_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_matrix_scanner.sv
// tb/tb_key_matrix_scanner.sv - randomized and directed bench for key_matrix_scanner against a frame-level key model
// Honours KEYSCAN_RELEASE_EVT_EN the same way as the design.
module tb_key_matrix_scanner;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NK   = ROWS * COLS;
  localparam int DEB  = 4;
`ifdef KEYSCAN_RELEASE_EVT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif
  localparam logic [COLS-1:0] FIRST_COL = 4'b1110;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic            evt_valid;
  logic            evt_ready = 1'b1;
  logic [3:0]      evt_code;
  logic            evt_press;

  logic [NK-1:0]   keys = '0;
  int              mode = 0;
  logic [31:0]     mask = '0;
  int              frame_no = 0;
  int              n_evt = 0;
  int              n_vec = 0;
  int              n_err = 0;

  bit              m_stable [NK];
  int              m_count [NK];
  int              q [$];
  logic [COLS-1:0] prev_col = '1;
  bit              p_hold = 0;
  logic [3:0]      p_code;
  logic            p_press;

  key_matrix_scanner dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_press(evt_press)
  );

  always #5 clk = ~clk;

  // Passive matrix: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_n = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!col_n[c] && keys[c*ROWS + r]) row_n[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < NK; k++) begin
      m_stable[k] = 0;
      m_count[k]  = 0;
    end
    q.delete();
    frame_no = 0;
    n_evt    = 0;
    prev_col = '1;
    p_hold   = 0;
  endtask

  // One whole frame: every key sees the matrix state held for that frame, in index order.
  task automatic model_frame();
    for (int k = 0; k < NK; k++) begin
      bit s;
      s = keys[k];
      if (s == m_stable[k]) m_count[k] = 0;
      else if (m_count[k] < DEB - 1) m_count[k]++;
      else begin
        m_stable[k] = s;
        m_count[k]  = 0;
        if (s || REL_EN) q.push_back(k*2 + int'(s));
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (evt_valid && evt_ready) begin
        chk("evt_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          int e;
          e = q.pop_front();
          chk("evt_code", evt_code, e / 2);
          chk("evt_press", evt_press, e % 2);
        end
        n_evt++;
      end
      if (p_hold) begin
        chk("hold_valid", evt_valid, 1);
        chk("hold_code", evt_code, p_code);
        chk("hold_press", evt_press, p_press);
      end
      p_hold  = evt_valid && !evt_ready;
      p_code  = evt_code;
      p_press = evt_press;
      chk("col_n_legal", (col_n == '1) || ($countones(~col_n) == 1), 1);
      if (col_n == FIRST_COL && prev_col != FIRST_COL) begin
        frame_no++;
        if (mode == 1) begin
          for (int k = 0; k < NK; k++)
            if ($urandom_range(0, 7) == 0) keys[k] = ~keys[k];
        end else if (mode == 2 && frame_no < 32) begin
          keys[9] = mask[frame_no];
        end
        model_frame();
      end
      prev_col = col_n;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_frame(input int target);
    for (int i = 0; i < 12000 && frame_no < target; i++) @(posedge clk);
    chk("frame_reached", frame_no >= target, 1);
  endtask

  task automatic measure(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1 n++;
      if (evt_valid) break;
    end
  endtask

  initial begin
    int lat;
    logic [COLS-1:0] want;

    // Idle scan: 21 cycles low per column, 1 cycle all ones.
    keys = '0; mode = 0; evt_ready = 1'b1;
    do_reset();
    chk("rst_col_n", col_n, 4'b1111);
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", evt_code, 0);
    chk("rst_press", evt_press, 0);
    for (int i = 0; i < 88; i++) begin
      @(posedge clk);
      @(negedge clk);
      want = ((i % 22) < 21) ? ~(4'(1) << (i / 22)) : 4'b1111;
      chk("idle_col_n", col_n, want);
    end
    wait_frame(4);
    chk("idle_no_evt", n_evt, 0);

    // Key 9 held from reset: press after its 4th scan.
    @(posedge clk); #1 keys = '0; keys[9] = 1'b1;
    do_reset();
    measure(lat);
    chk("key9_latency", lat, 327);
    chk("key9_code", evt_code, 9);
    chk("key9_press", evt_press, 1);
    wait_frame(12);
    chk("key9_single", n_evt, 1);

    // Press for frames 1..5 then release.
    @(posedge clk); #1 keys = '0; mode = 2; mask = 32'h0000_003E;
    do_reset();
    wait_frame(11);
    chk("release_evts", n_evt, REL_EN ? 2 : 1);

    // Two 3-scan glitches separated by one open scan.
    @(posedge clk); #1 keys = '0; mode = 2; mask = 32'h0000_00EE;
    do_reset();
    wait_frame(10);
    chk("glitch_evts", n_evt, 0);

    // Keys 4 and 7 with the consumer stalled.
    @(posedge clk); #1 keys = '0; keys[4] = 1'b1; keys[7] = 1'b1; mode = 0; evt_ready = 1'b0;
    do_reset();
    measure(lat);
    chk("stall_latency", lat, 304);
    chk("stall_code4", evt_code, 4);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_col_n", col_n, 4'b1101);
    chk("stall_valid", evt_valid, 1);
    chk("stall_code_held", evt_code, 4);
    evt_ready = 1'b1;
    @(posedge clk); #1 evt_ready = 1'b0;
    chk("handoff_valid", evt_valid, 1);
    chk("handoff_code7", evt_code, 7);
    chk("handoff_press", evt_press, 1);

    // Reset in the middle of a stall.
    @(posedge clk); #1 keys = '0; keys[4] = 1'b1; keys[7] = 1'b1;
    do_reset();
    measure(lat);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", evt_valid, 0);
    chk("midrst_col_n", col_n, 4'b1111);
    evt_ready = 1'b1;
    do_reset();
    measure(lat);
    chk("rereport_latency", lat, 304);
    chk("rereport_code", evt_code, 4);
    chk("rereport_press", evt_press, 1);

    // Last column wraps back to column 0.
    @(posedge clk); #1 keys = '0; keys[15] = 1'b1;
    do_reset();
    measure(lat);
    chk("key15_latency", lat, 351);
    chk("key15_code", evt_code, 15);
    for (int i = 0; i < 100 && (col_n == 4'b0111 || col_n == 4'b1111); i++) @(negedge clk);
    chk("wrap_col_n", col_n, 4'b1110);

    // Random matrix activity with random back-pressure.
    @(posedge clk); #1 keys = '0; mode = 1;
    do_reset();
    for (int i = 0; i < 30000 && frame_no < 40; i++) begin
      @(posedge clk);
      #1 evt_ready = ($urandom_range(0, 9) < 6);
    end
    chk("rand_frames", frame_no >= 40, 1);
    mode = 0; evt_ready = 1'b1;
    wait_frame(frame_no + 6);
    chk("rand_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/key_matrix_scanner.md
# key_matrix_scanner

Scans a ROWS×COLS passive key matrix by driving one column low at a time and sampling the row lines. Each key is debounced over several consecutive scans, and debounced state changes are delivered as press/release events on a valid/ready stream. It sits between the board keypad pins and the CPU-facing event interface. It replaces per-pin debouncers with one shared, time-multiplexed debounce engine.

## Interface
- ROWS, 4: number of row inputs; ≥1.
- COLS, 4: number of column outputs; ≥1.
- SETTLE_CYCLES, 16: cycles between column drive and first row sample; ≥3, covers pin settling plus synchroniser latency.
- DEBOUNCE_SCANS, 4: consecutive disagreeing scans needed to flip a key's stable state; ≥1.
- clk  in  1  50 MHz clock.
- rst  in  1  reset, asynchronous, active-high.
- col_n  out  COLS  column drive, active-low, one-cold; all ones when idle.
- row_n  in  ROWS  asynchronous row inputs, pulled up; low = key closed on the driven column.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready at posedge.
- evt_code  out  $clog2(ROWS*COLS) (min 1)  key index = col*ROWS + row.
- evt_press  out  1  1 = press, 0 = release.

## Operation
- row_n passes through a 2-flop synchroniser per bit, then is inverted to pressed = 1.
- Per-key state: stable bit plus count[$clog2(DEBOUNCE_SCANS+1)-1:0].
- FSM states: DRIVE → SETTLE → SAMPLE → NEXT → DRIVE.
  - DRIVE (1 cycle): col_n[col] <= 0, all other bits 1.
  - SETTLE: counts SETTLE_CYCLES cycles.
  - SAMPLE: visits row r = 0..ROWS-1, one key per cycle.
  - NEXT (1 cycle): col_n <= all ones; col <= (col == COLS-1) ? 0 : col+1.
- Key update in SAMPLE, when the key's sample equals stable: count <= 0.
- Key update in SAMPLE, when the sample differs and count < DEBOUNCE_SCANS-1: count <= count+1.
- Key update in SAMPLE, when the sample differs and count == DEBOUNCE_SCANS-1: stable <= sample, count <= 0, and an event is generated.
- Event slot: a single register.
  - On generate, it loads evt_code = col*ROWS+r and evt_press = sample, and sets evt_valid.
  - evt_valid clears on handshake unless the same cycle loads a new event.
- Stall: if the key under evaluation would generate an event while evt_valid && !evt_ready, the FSM holds in SAMPLE on the same r.
  - During a stall, no key state changes and col_n is held.
  - Evaluation resumes in the handshake cycle, so an event is loaded in the same cycle the old one is accepted.
  - Events are never dropped. Event order is scan order.
- Keys that do not generate events advance one per cycle and never stall.

## Timing
- Reset values:
  - col_n = all ones, evt_valid = 0, evt_code = 0, evt_press = 0.
  - All stable = 0 (released), all count = 0.
  - State = DRIVE, col = 0, r = 0.
- Unstalled column period = SETTLE_CYCLES + ROWS + 2 cycles; full frame = COLS × that.
- Event latency: evt_valid rises the cycle after the SAMPLE cycle of the flipping key, on the DEBOUNCE_SCANS-th consecutive differing scan.
- Glitch shorter than DEBOUNCE_SCANS scans: no event. The count returns to 0 on the first agreeing scan.
- Multiple keys flipping in one column: evaluated in ascending row order. Each waits for the slot.
- Wrap-around: col COLS-1 → 0. Key index covers 0..ROWS*COLS-1 only.
- evt_code/evt_press are stable while evt_valid && !evt_ready.
- Reset mid-scan or mid-stall: everything returns to reset values and any pending event is discarded. Keys held through reset report a press DEBOUNCE_SCANS frames later.

## Configuration
- KEYSCAN_RELEASE_EVT_EN defined: both press and release events are generated as above.
- KEYSCAN_RELEASE_EVT_EN undefined: a debounced transition to released updates stable and count normally but generates no event and never stalls. evt_press is then always 1 when evt_valid.

## Test plan
Default parameters (4×4, SETTLE_CYCLES=16, DEBOUNCE_SCANS=4), evt_ready=1 unless stated.

- Reset, no keys → col_n cycles 1110, 1101, 1011, 0111. Each column is low for SETTLE_CYCLES+ROWS+1 = 21 cycles, then all ones for 1 cycle in NEXT; column period 22 cycles. evt_valid stays 0.
- Hold row 1 low whenever col 2 is driven → exactly one event, code 9, press 1, after the 4th scan of col 2. Releasing it gives code 9, press 0 after 4 scans; with the macro undefined, no release event.
- Key 9 closed for 3 scans then open → no event, count back to 0.
- Rows 0 and 3 both pressed on col 1, evt_ready=0 → code 4 is presented. The FSM stalls at row 3 with col_n=1101 held. Raising evt_ready for one cycle gives code 4 accepted and code 7 loaded in that same cycle.
- Key 15 pressed on col 3 (last column) → event code 15. Scanning wraps to col 0 with col_n=1110.
- Assert rst during a stall with evt_valid=1 → evt_valid=0, col_n=all ones immediately. Scanning restarts at col 0, and the held key re-reports a press after 4 frames.
